// File: rtl/complex_accum_dump.sv
// Coherent block accumulator: sums N complex products, then dumps a rounded and saturated result.
// Latency: result registers on the edge after the Nth accept. There is no backpressure: every in_valid is taken.
module complex_accum_dump #(
   parameter int IN_W  = 38,
   parameter int ACC_W = 44,
   parameter int N     = 16,
   parameter int SHIFT = 20,
   parameter int OUT_W = 18
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_real,
   input  logic [IN_W-1:0]  in_imag,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_real,
   output logic [OUT_W-1:0] out_imag,
   output logic             out_sat,
   output logic             busy
);

   localparam int CW = $clog2(N);

   if (ACC_W < IN_W + $clog2(N)) begin : g_bad_accw
      $error("complex_accum_dump: ACC_W too narrow for IN_W and N");
   end
   if (N < 2 || N > 65535) begin : g_bad_n
      $error("complex_accum_dump: N out of range");
   end
   if (SHIFT < 0 || SHIFT > ACC_W - 1) begin : g_bad_shift
      $error("complex_accum_dump: SHIFT out of range");
   end

   localparam logic signed [ACC_W:0] RND =
      (SHIFT == 0) ? '0 : ({{ACC_W{1'b0}}, 1'b1} << ((SHIFT == 0) ? 0 : SHIFT - 1));
   localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

   logic [CW-1:0]    count;
   logic [ACC_W-1:0] acc_re;
   logic [ACC_W-1:0] acc_im;
   logic             dump_pend;
   logic [ACC_W-1:0] ext_re;
   logic [ACC_W-1:0] ext_im;
   logic [OUT_W:0]   dump_re;
   logic [OUT_W:0]   dump_im;

   // Round half-up via bias then floor shift; MSB of the result is the clip flag.
   function automatic logic [OUT_W:0] round_sat(input logic [ACC_W-1:0] a);
      logic signed [ACC_W:0] t;
      logic signed [ACC_W:0] s;
      t = $signed({a[ACC_W-1], a}) + RND;
      s = t >>> SHIFT;
      if (s > MAXV)
         round_sat = {1'b1, MAXV[OUT_W-1:0]};
      else if (s < MINV)
         round_sat = {1'b1, MINV[OUT_W-1:0]};
      else
         round_sat = {1'b0, s[OUT_W-1:0]};
   endfunction

   always_comb begin
      ext_re  = {{(ACC_W - IN_W){in_real[IN_W-1]}}, in_real};
      ext_im  = {{(ACC_W - IN_W){in_imag[IN_W-1]}}, in_imag};
      dump_re = round_sat(acc_re);
      dump_im = round_sat(acc_im);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count     <= '0;
         acc_re    <= '0;
         acc_im    <= '0;
         dump_pend <= 1'b0;
         out_valid <= 1'b0;
         out_real  <= '0;
         out_imag  <= '0;
         out_sat   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         // Dump samples the finished sum while a new block may load on this same edge.
         if (dump_pend) begin
            out_real  <= dump_re[OUT_W-1:0];
            out_imag  <= dump_im[OUT_W-1:0];
            out_sat   <= dump_re[OUT_W] | dump_im[OUT_W];
            out_valid <= 1'b1;
            dump_pend <= 1'b0;
         end
         if (in_valid) begin
            if (count == '0) begin
               acc_re <= ext_re;
               acc_im <= ext_im;
            end else begin
               acc_re <= acc_re + ext_re;
               acc_im <= acc_im + ext_im;
            end
            if (count == CW'(N - 1)) begin
               count     <= '0;
               dump_pend <= 1'b1;
               busy      <= 1'b0;
            end else begin
               count <= count + 1'b1;
               busy  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_complex_accum_dump.sv
// Randomized and directed bench for complex_accum_dump with a queue-based block-sum reference model.
module tb_complex_accum_dump;

   localparam int IN_W  = 38;
   localparam int OUT_W = 18;
   localparam int NB    = 4;
   localparam int SH    = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic [IN_W-1:0]  in_real = '0;
   logic [IN_W-1:0]  in_imag = '0;
   logic             out_valid;
   logic [OUT_W-1:0] out_real;
   logic [OUT_W-1:0] out_imag;
   logic             out_sat;
   logic             busy;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit check_en = 1'b0;

   // reference model state
   longint blk_re[$];
   longint blk_im[$];
   bit     due = 1'b0;
   longint due_re, due_im;
   bit     exp_valid = 1'b0;
   longint exp_re = 0, exp_im = 0;
   bit     exp_sat = 1'b0;
   bit     exp_busy = 1'b0;

   // observed pulses
   longint pr_q[$];
   longint pi_q[$];
   bit     ps_q[$];
   int     pc_q[$];

   complex_accum_dump #(.IN_W(IN_W), .ACC_W(44), .N(NB), .SHIFT(SH), .OUT_W(OUT_W)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
      .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag), .out_sat(out_sat), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Floor((sum + 2^(SH-1)) / 2^SH), then clip to OUT_W signed range.
   function automatic longint ref_round(input longint s, output bit clip);
      longint t, q, hi, lo;
      t = s + (longint'(1) << (SH - 1));
      q = t / (longint'(1) << SH);
      if (t < 0 && (t % (longint'(1) << SH)) != 0) q = q - 1;
      hi = (longint'(1) << (OUT_W - 1)) - 1;
      lo = -(longint'(1) << (OUT_W - 1));
      clip = 1'b0;
      if (q > hi) begin q = hi; clip = 1'b1; end
      if (q < lo) begin q = lo; clip = 1'b1; end
      return q;
   endfunction

   always @(posedge clock) begin
      bit c1, c2;
      longint sr, si;
      cyc++;
      if (reset) begin
         blk_re.delete(); blk_im.delete();
         due = 1'b0; exp_valid = 1'b0; exp_re = 0; exp_im = 0; exp_sat = 1'b0; exp_busy = 1'b0;
      end else begin
         exp_valid = 1'b0;
         if (due) begin
            exp_re = ref_round(due_re, c1);
            exp_im = ref_round(due_im, c2);
            exp_sat = c1 | c2;
            exp_valid = 1'b1;
            due = 1'b0;
         end
         if (in_valid) begin
            blk_re.push_back(longint'($signed(in_real)));
            blk_im.push_back(longint'($signed(in_imag)));
            if (blk_re.size() == NB) begin
               sr = 0; si = 0;
               foreach (blk_re[i]) begin sr += blk_re[i]; si += blk_im[i]; end
               due_re = sr; due_im = si; due = 1'b1;
               blk_re.delete(); blk_im.delete();
            end
         end
         exp_busy = (blk_re.size() != 0);
      end
   end

   always @(negedge clock) begin
      if (check_en) begin
         chk("out_valid", longint'(out_valid), longint'(exp_valid));
         chk("busy", longint'(busy), longint'(exp_busy));
         chk("out_real", longint'($signed(out_real)), exp_re);
         chk("out_imag", longint'($signed(out_imag)), exp_im);
         if (exp_valid) chk("out_sat", longint'(out_sat), longint'(exp_sat));
      end
      if (out_valid === 1'b1) begin
         pr_q.push_back(longint'($signed(out_real)));
         pi_q.push_back(longint'($signed(out_imag)));
         ps_q.push_back(out_sat);
         pc_q.push_back(cyc);
      end
   end

   task automatic send(input longint re, input longint im);
      @(posedge clock); #1;
      in_valid = 1'b1;
      in_real  = re[IN_W-1:0];
      in_imag  = im[IN_W-1:0];
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic block(input longint re, input longint im);
      for (int i = 0; i < NB; i++) send(re, im);
      idle(4);
   endtask

   initial begin
      longint big_p, big_n;
      int np;
      logic [IN_W-1:0] rv;
      big_p = (longint'(1) << 37) - 1;
      big_n = -(longint'(1) << 37);

      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check_en = 1'b1;
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_out_real", longint'($signed(out_real)), 0);
      chk("reset_busy", longint'(busy), 0);

      // basic block
      np = pr_q.size();
      block(16, -16);
      chk("basic_pulses", pr_q.size(), np + 1);
      chk("basic_re", pr_q[$], 4);
      chk("basic_im", pi_q[$], -4);
      chk("basic_sat", longint'(ps_q[$]), 0);

      // rounding ties
      block(2, -2);
      chk("tie_re", pr_q[$], 1);
      chk("tie_im", pi_q[$], 0);
      block(0, -14);
      chk("tie_neg_im", pi_q[$], -3);

      // saturation, then recovery
      block(big_p, big_n);
      chk("sat_re", pr_q[$], 131071);
      chk("sat_im", pi_q[$], -131072);
      chk("sat_flag", longint'(ps_q[$]), 1);
      block(16, 16);
      chk("unsat_flag", longint'(ps_q[$]), 0);

      // gapped input
      np = pr_q.size();
      for (int i = 0; i < NB; i++) begin
         send(16, -16);
         idle($urandom_range(1, 3));
      end
      idle(4);
      chk("gap_pulses", pr_q.size(), np + 1);
      chk("gap_re", pr_q[$], 4);
      chk("gap_im", pi_q[$], -4);

      // back-to-back blocks
      np = pr_q.size();
      for (int i = 0; i < NB; i++) send(16, 0);
      for (int i = 0; i < NB; i++) send(32, 0);
      idle(4);
      chk("b2b_pulses", pr_q.size(), np + 2);
      chk("b2b_first", pr_q[$-1], 4);
      chk("b2b_second", pr_q[$], 8);
      chk("b2b_spacing", pc_q[$] - pc_q[$-1], 4);

      // reset mid-block
      np = pr_q.size();
      send(1000, 1000);
      send(1000, 1000);
      do_reset();
      chk("mid_rst_real", longint'($signed(out_real)), 0);
      chk("mid_rst_valid", longint'(out_valid), 0);
      chk("mid_rst_busy", longint'(busy), 0);
      block(16, 0);
      chk("mid_rst_pulses", pr_q.size(), np + 1);
      chk("mid_rst_re", pr_q[$], 4);

      // randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         int sel;
         longint re, im;
         sel = $urandom_range(0, 99);
         if (sel < 2) begin
            do_reset();
         end else if (sel < 30) begin
            idle(1);
         end else begin
            if ($urandom_range(0, 1) == 0) begin
               re = longint'($urandom_range(0, 4000)) - 2000;
               im = longint'($urandom_range(0, 4000)) - 2000;
            end else if ($urandom_range(0, 3) == 0) begin
               re = ($urandom_range(0, 1) == 0) ? big_p : big_n;
               im = ($urandom_range(0, 1) == 0) ? big_p : big_n;
            end else begin
               rv = IN_W'({$urandom(), $urandom()});
               re = longint'($signed(rv));
               rv = IN_W'({$urandom(), $urandom()});
               im = longint'($signed(rv));
            end
            send(re, im);
         end
      end
      idle(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
